// File: rtl/division_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// step-counter sizing helper.
package division_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/division_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor, keep the difference when it is non-negative.
module division_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor};
        // Top bit of the extended difference is the borrow: restore on borrow.
        if (trial[WIDTH]) begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/division_seq.sv
// Multi-cycle restoring divider, fixed WIDTH+1 edge latency, busy/done handshake.
// Define DIV_SIGNED_EN to honour signed_op (two's-complement, truncating divide).
module division_seq
    import division_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only in IDLE or DONE (accept edge T0); busy is
    // high for the WIDTH cycles of RUN and start is ignored there; done pulses for
    // one cycle in DONE, from which q/r/div_by_zero are valid and held until the
    // next completion. Accepting in DONE gives back-to-back operation.
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] res_q, res_r;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    always_comb begin
        a_neg = signed_op & a[WIDTH-1];
        b_neg = signed_op & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        // A zero divisor keeps the all-ones quotient; the remainder sign fix
        // then reproduces the original dividend.
        res_q = (qneg_q && (div_q != '0)) ? -step_quo : step_quo;
        res_r = rneg_q ? -step_rem : step_rem;
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;

    always_comb begin
        a_mag = a;
        b_mag = b;
        res_q = step_quo;
        res_r = step_rem;
    end
`endif

    division_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    div_d   = b_mag;
`ifdef DIV_SIGNED_EN
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    q_d     = res_q;
                    r_d     = res_r;
                    dbz_d   = (div_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_division_seq.sv
// Self-checking bench for division_seq (WIDTH=32): directed table, handshake
// corner sequences, and random operations against an arithmetic reference.
module tb_division_seq;
    import division_pkg::*;

    localparam int W = 32;
    typedef logic [2*W:0] res_t;  // {div_by_zero, r, q}

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] q, r;
    logic         busy, done, div_by_zero;
    logic [1:0]   state_dbg;

    int   n_checks = 0;
    int   n_fail = 0;
    res_t exp_q[$];
    vec_t vecs[8];

    division_seq #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic from the divider's rules.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sop);
        logic [W-1:0] mq, mr;
        logic         z;
`ifndef DIV_SIGNED_EN
        logic         unused_sop;
        unused_sop = sop;
`endif
        z = (y == '0);
        if (z) begin
            mq = '1;
            mr = x;
        end
`ifdef DIV_SIGNED_EN
        else if (sop) begin
            longint sx, sy;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            mq = W'(sx / sy);
            mr = W'(sx % sy);
        end
`endif
        else begin
            mq = x / y;
            mr = x % y;
        end
        return {z, mr, mq};
    endfunction

    // driver: pops the next expected result, runs one operation from an
    // accept edge to its done pulse and scores it.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sop,
                          input string tag, input bit poke, input bit hold);
        res_t         e;
        int           lat;
        int           busy_cnt;
        logic [W-1:0] prev_q;
        e = exp_q.pop_front();
        prev_q = q;
        a = x;
        b = y;
        signed_op = sop;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        signed_op = 1'($urandom_range(0, 1));
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (lat == 10) check({tag, " q held during run"}, q, prev_q);
            if (poke && lat == 5) begin
                start = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end else if (poke && lat == 7) begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 33);
        check({tag, " busy cycles"}, busy_cnt, 32);
        check({tag, " done"}, done, 1);
        check({tag, " q"}, q, e[W-1:0]);
        check({tag, " r"}, r, e[2*W-1:W]);
        check({tag, " div_by_zero"}, div_by_zero, e[2*W]);
        if (hold) begin
            @(posedge clock);
            #1;
            check({tag, " done pulse width"}, done, 0);
            check({tag, " busy after done"}, busy, 0);
            check({tag, " q hold"}, q, e[W-1:0]);
            check({tag, " r hold"}, r, e[2*W-1:W]);
        end
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         sop;

        vecs[0] = '{32'd5,          32'd9,          32'd0,          32'd5,  1'b0};
        vecs[1] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15, 1'b0};
        vecs[3] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,  1'b1};
        vecs[4] = '{32'd1000,       32'd3,          32'd333,        32'd1,  1'b0};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0};
        vecs[6] = '{32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  32'd0,  1'b0};
        vecs[7] = '{32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1,  1'b0};

        // reset state
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset q", q, 0);
        check("reset r", r, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_by_zero", div_by_zero, 0);
        check("reset state", state_dbg, S_IDLE);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // directed table
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].edbz, vecs[i].er, vecs[i].eq});
            run_op(vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), 1'b0, 1'b1);
        end

        // back-to-back: second start lands in the DONE cycle
        exp_q.push_back({1'b0, 32'd2, 32'd14});
        exp_q.push_back({1'b0, 32'd15, 32'h0FFF_FFFF});
        run_op(32'd100, 32'd7, 1'b0, "b2b first", 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd16, 1'b0, "b2b second", 1'b0, 1'b1);

        // divide by zero with start pulsed while busy
        exp_q.push_back({1'b1, 32'd7, 32'hFFFF_FFFF});
        run_op(32'd7, 32'd0, 1'b0, "dbz poke", 1'b1, 1'b1);

        // reset mid-run, then a fresh operation
        a = 32'd1000;
        b = 32'd3;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort q", q, 0);
        check("abort r", r, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort div_by_zero", div_by_zero, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("abort stays idle", state_dbg, S_IDLE);
        exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
        run_op(32'd1000, 32'd3, 1'b0, "after abort", 1'b0, 1'b1);

`ifdef DIV_SIGNED_EN
        exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s -7/2", 1'b0, 1'b1);
        exp_q.push_back({1'b0, 32'd1, 32'hFFFF_FFFD});
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s 7/-2", 1'b0, 1'b1);
        exp_q.push_back({1'b0, 32'd0, 32'h8000_0000});
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s min/-1", 1'b0, 1'b1);
        exp_q.push_back({1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, "s -7/0", 1'b0, 1'b1);
`endif

        // random operations against the reference
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = $urandom;
                default: y = x >> $urandom_range(0, 8);
            endcase
            sop = 1'($urandom_range(0, 1));
            exp_q.push_back(model(x, y, sop));
            run_op(x, y, sop, $sformatf("rand%0d", i), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
